cmd_encod_seq: RTL and testbench

Command sequencer that feeds the DDR3 command/address PHY. It accepts queued memory commands over a valid/ready handshake and encodes them into active-low RAS/CAS/WE. Each command is placed in one of the two clk_div slots, with the programmed inter-command gaps filled with NOPs. Its outputs connect directly to the PHY's two-bits-per-signal inputs (bit[0]/low half = first slot, bit[1]/high half = second slot).

---
 rtl/cmd_encod_seq_pkg.sv | 39 +++
 rtl/cmd_encod_slot.sv | 31 +++
 rtl/cmd_encod_seq.sv | 159 +++++++++++++++
 tb/tb_cmd_encod_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cmd_encod_seq_pkg.sv
// Shared DDR3 command definitions for the command sequencer.
// Command codes, slot indices, FSM states and the RAS/CAS/WE encoder.
package cmd_encod_seq_pkg;

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;
    localparam logic [2:0] CMD_REF = 3'd5;
    localparam logic [2:0] CMD_MRS = 3'd6;
    localparam logic [2:0] CMD_ZQC = 3'd7;

    localparam logic SLOT_FIRST  = 1'b0;
    localparam logic SLOT_SECOND = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } seq_state_e;

    // Active-low {ras, cas, we}
    function automatic logic [2:0] cmd_rcw(input logic [2:0] code);
        logic [2:0] rcw;
        case (code)
            CMD_ACT: rcw = 3'b011;
            CMD_RD:  rcw = 3'b101;
            CMD_WR:  rcw = 3'b100;
            CMD_PRE: rcw = 3'b010;
            CMD_REF: rcw = 3'b001;
            CMD_MRS: rcw = 3'b000;
            CMD_ZQC: rcw = 3'b110;
            default: rcw = 3'b111;
        endcase
        return rcw;
    endfunction

endpackage

// File: rtl/cmd_encod_slot.sv
// Places an encoded command in one clk_div slot; the other slot gets NOP.
// Bit 0 of each pair is the first slot, bit 1 the second.
module cmd_encod_slot
    import cmd_encod_seq_pkg::*;
(
    input  logic [2:0] code,
    input  logic       slot,
    output logic [1:0] ras,
    output logic [1:0] cas,
    output logic [1:0] we
);

    logic [2:0] rcw;

    always_comb begin
        rcw = cmd_rcw(code);
        ras = 2'b11;
        cas = 2'b11;
        we  = 2'b11;
        if (slot == SLOT_FIRST) begin
            ras[0] = rcw[2];
            cas[0] = rcw[1];
            we[0]  = rcw[0];
        end else begin
            ras[1] = rcw[2];
            cas[1] = rcw[1];
            we[1]  = rcw[0];
        end
    end

endmodule

// File: rtl/cmd_encod_seq.sv
// DDR3 command sequencer: accepts queued commands, drives the PHY
// command/address pairs and pads each command with its NOP gap.
module cmd_encod_seq
    import cmd_encod_seq_pkg::*;
#(
    parameter int ADDRESS_NUMBER = 15,
    parameter int SKIP_WIDTH     = 10
) (
    input  logic                        clk_div,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [2:0]                  cmd_code,
    input  logic                        cmd_slot,
    input  logic [2:0]                  cmd_bank,
    input  logic [ADDRESS_NUMBER-1:0]   cmd_addr,
    input  logic [SKIP_WIDTH-1:0]       cmd_skip,
    input  logic                        cmd_cke,
    input  logic                        cmd_odt,
    input  logic                        cmd_tri,
    input  logic                        cmd_last,
    input  logic                        abort,
    output logic [2*ADDRESS_NUMBER-1:0] in_a,
    output logic [5:0]                  in_ba,
    output logic [1:0]                  in_we,
    output logic [1:0]                  in_ras,
    output logic [1:0]                  in_cas,
    output logic [1:0]                  in_cke,
    output logic [1:0]                  in_odt,
    output logic                        in_tri,
    output logic                        busy,
    output logic                        done
);

    localparam logic [SKIP_WIDTH-1:0] SKIP_ONE = SKIP_WIDTH'(1);

    seq_state_e                state_q, state_d;
    logic [SKIP_WIDTH-1:0]     skip_cnt_q, skip_cnt_d;
    logic [ADDRESS_NUMBER-1:0] a_q, a_d;
    logic [2:0]                ba_q, ba_d;
    logic [1:0]                ras_q, ras_d;
    logic [1:0]                cas_q, cas_d;
    logic [1:0]                we_q, we_d;
    logic                      cke_q, cke_d;
    logic                      odt_q, odt_d;
    logic                      tri_q, tri_d;
    logic                      last_q, last_d;
    logic                      done_q, done_d;
    logic                      accept;
    logic [1:0]                enc_ras, enc_cas, enc_we;

    cmd_encod_slot u_slot (
        .code (cmd_code),
        .slot (cmd_slot),
        .ras  (enc_ras),
        .cas  (enc_cas),
        .we   (enc_we)
    );

    always_comb begin
        cmd_ready = 1'b0;
        if (rst_n && !abort) begin
            unique case (state_q)
                ST_IDLE:  cmd_ready = 1'b1;
                ST_ISSUE: cmd_ready = (skip_cnt_q == '0);
                ST_WAIT:  cmd_ready = (skip_cnt_q == SKIP_ONE);
                default:  cmd_ready = 1'b0;
            endcase
        end
    end

    assign accept = cmd_valid & cmd_ready;

    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        a_d        = a_q;
        ba_d       = ba_q;
        ras_d      = 2'b11;
        cas_d      = 2'b11;
        we_d       = 2'b11;
        cke_d      = cke_q;
        odt_d      = odt_q;
        tri_d      = tri_q;
        last_d     = last_q;
        if (abort) begin
            state_d    = ST_IDLE;
            skip_cnt_d = '0;
        end else if (accept) begin
            state_d    = ST_ISSUE;
            skip_cnt_d = cmd_skip;
            a_d        = cmd_addr;
            ba_d       = cmd_bank;
            ras_d      = enc_ras;
            cas_d      = enc_cas;
            we_d       = enc_we;
            cke_d      = cmd_cke;
            odt_d      = cmd_odt;
            tri_d      = cmd_tri;
            last_d     = cmd_last;
        end else begin
            unique case (state_q)
                ST_ISSUE: state_d = (skip_cnt_q == '0) ? ST_IDLE : ST_WAIT;
                ST_WAIT: begin
                    skip_cnt_d = skip_cnt_q - SKIP_ONE;
                    if (skip_cnt_q == SKIP_ONE) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        // Flag the final NOP (or the command itself when there is no gap)
        done_d = (accept && cmd_last && cmd_skip == '0)
               || (!abort && state_d == ST_WAIT
                   && skip_cnt_d == SKIP_ONE && last_q);
    end

    always_ff @(posedge clk_div) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            skip_cnt_q <= '0;
            a_q        <= '0;
            ba_q       <= '0;
            ras_q      <= 2'b11;
            cas_q      <= 2'b11;
            we_q       <= 2'b11;
            cke_q      <= 1'b0;
            odt_q      <= 1'b0;
            tri_q      <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_cnt_q <= skip_cnt_d;
            a_q        <= a_d;
            ba_q       <= ba_d;
            ras_q      <= ras_d;
            cas_q      <= cas_d;
            we_q       <= we_d;
            cke_q      <= cke_d;
            odt_q      <= odt_d;
            tri_q      <= tri_d;
            last_q     <= last_d;
            done_q     <= done_d;
        end
    end

    assign in_a   = {a_q, a_q};
    assign in_ba  = {ba_q, ba_q};
    assign in_ras = ras_q;
    assign in_cas = cas_q;
    assign in_we  = we_q;
    assign in_cke = {2{cke_q}};
    assign in_odt = {2{odt_q}};
    assign in_tri = tri_q;
    assign done   = done_q;
    assign busy   = (state_q != ST_IDLE)
                  || ({ras_q, cas_q, we_q} != 6'b111111);

endmodule

// File: tb/tb_cmd_encod_seq.sv
// Directed testbench for cmd_encod_seq.
// Inputs change 1 time unit after a rising edge; outputs checked there.
module tb_cmd_encod_seq;

    localparam int AN = 15;
    localparam int SW = 10;

    logic          clk_div = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_code;
    logic          cmd_slot;
    logic [2:0]    cmd_bank;
    logic [AN-1:0] cmd_addr;
    logic [SW-1:0] cmd_skip;
    logic          cmd_cke, cmd_odt, cmd_tri, cmd_last;
    logic          abort;
    logic [2*AN-1:0] in_a;
    logic [5:0]    in_ba;
    logic [1:0]    in_we, in_ras, in_cas, in_cke, in_odt;
    logic          in_tri, busy, done;

    int n_checks = 0;
    int n_errors = 0;
    int nops;

    cmd_encod_seq #(.ADDRESS_NUMBER(AN), .SKIP_WIDTH(SW)) dut (
        .clk_div   (clk_div),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_code  (cmd_code),
        .cmd_slot  (cmd_slot),
        .cmd_bank  (cmd_bank),
        .cmd_addr  (cmd_addr),
        .cmd_skip  (cmd_skip),
        .cmd_cke   (cmd_cke),
        .cmd_odt   (cmd_odt),
        .cmd_tri   (cmd_tri),
        .cmd_last  (cmd_last),
        .abort     (abort),
        .in_a      (in_a),
        .in_ba     (in_ba),
        .in_we     (in_we),
        .in_ras    (in_ras),
        .in_cas    (in_cas),
        .in_cke    (in_cke),
        .in_odt    (in_odt),
        .in_tri    (in_tri),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk_div = ~clk_div;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_div);
        #1;
    endtask

    task automatic put(input logic [2:0] code, input logic slot,
                       input logic [2:0] bank, input logic [AN-1:0] addr,
                       input logic [SW-1:0] skip, input logic cke,
                       input logic odt, input logic last);
        cmd_valid = 1'b1;
        cmd_code  = code;
        cmd_slot  = slot;
        cmd_bank  = bank;
        cmd_addr  = addr;
        cmd_skip  = skip;
        cmd_cke   = cke;
        cmd_odt   = odt;
        cmd_last  = last;
    endtask

    initial begin
        rst_n = 1'b0; abort = 1'b0; cmd_tri = 1'b0;
        put(3'd0, 1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b0);
        cmd_valid = 1'b0;
        repeat (3) step();
        check("rst_ras", 64'(in_ras), 64'h3);
        check("rst_cke", 64'(in_cke), 64'h0);
        check("rst_ready", 64'(cmd_ready), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);

        rst_n = 1'b1;
        repeat (5) step();
        check("idle_wrc", 64'({in_we, in_ras, in_cas}), 64'h3f);
        check("idle_a", 64'(in_a), 64'h0);
        check("idle_cke", 64'(in_cke), 64'h0);
        check("idle_ready", 64'(cmd_ready), 64'h1);
        check("idle_busy", 64'(busy), 64'h0);

        // ACT bank 3 addr 0x1234 slot 0 skip 4
        put(3'd1, 1'b0, 3'd3, 15'h1234, 10'd4, 1'b1, 1'b0, 1'b0);
        step();
        cmd_valid = 1'b0;
        check("act_ras", 64'(in_ras), 64'h2);
        check("act_cas_we", 64'({in_cas, in_we}), 64'hf);
        check("act_ba", 64'(in_ba), 64'h1b);
        check("act_a", 64'(in_a), {34'd0, 15'h1234, 15'h1234});
        check("act_cke", 64'(in_cke), 64'h3);
        check("act_ready", 64'(cmd_ready), 64'h0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check("act_gap_nop", 64'({in_we, in_ras, in_cas}), 64'h3f);
            check("act_gap_ready", 64'(cmd_ready), 64'(i == 4));
        end

        // WR slot 1 then RD slot 0, both skip 0
        put(3'd3, 1'b1, 3'd2, 15'h0042, 10'd0, 1'b1, 1'b0, 1'b0);
        step();
        check("wr_we", 64'(in_we), 64'h1);
        check("wr_cas", 64'(in_cas), 64'h1);
        check("wr_ras", 64'(in_ras), 64'h3);
        check("wr_ready", 64'(cmd_ready), 64'h1);
        put(3'd2, 1'b0, 3'd5, 15'h0055, 10'd0, 1'b1, 1'b0, 1'b0);
        step();
        cmd_valid = 1'b0;
        check("rd_cas", 64'(in_cas), 64'h2);
        check("rd_we_ras", 64'({in_we, in_ras}), 64'hf);
        check("rd_ba", 64'(in_ba), 64'h2d);
        step();
        check("rd_after_nop", 64'({in_we, in_ras, in_cas}), 64'h3f);
        check("rd_after_busy", 64'(busy), 64'h0);

        // MRS with last, skip 2, slot 1
        put(3'd6, 1'b1, 3'd1, 15'h0abc, 10'd2, 1'b1, 1'b0, 1'b1);
        step();
        cmd_valid = 1'b0; cmd_last = 1'b0;
        check("mrs_enc", 64'({in_ras, in_cas, in_we}), 64'h15);
        check("mrs_done0", 64'(done), 64'h0);
        step();
        check("mrs_nop1_done", 64'(done), 64'h0);
        check("mrs_nop1_busy", 64'(busy), 64'h1);
        step();
        check("mrs_nop2_done", 64'(done), 64'h1);
        step();
        check("mrs_end_done", 64'(done), 64'h0);
        check("mrs_end_busy", 64'(busy), 64'h0);

        // Abort during a skip-100 gap, with a WR presented
        put(3'd1, 1'b0, 3'd4, 15'h0777, 10'd100, 1'b1, 1'b1, 1'b1);
        step();
        cmd_valid = 1'b0;
        repeat (3) step();
        put(3'd3, 1'b0, 3'd6, 15'h0111, 10'd0, 1'b0, 1'b0, 1'b1);
        abort = 1'b1;
        #1;
        check("abort_ready", 64'(cmd_ready), 64'h0);
        step();
        abort = 1'b0; cmd_valid = 1'b0; cmd_last = 1'b0;
        check("abort_nop", 64'({in_we, in_ras, in_cas}), 64'h3f);
        check("abort_busy", 64'(busy), 64'h0);
        check("abort_done", 64'(done), 64'h0);
        check("abort_levels", 64'({in_cke, in_odt}), 64'hf);
        check("abort_a_held", 64'(in_a), {34'd0, 15'h0777, 15'h0777});
        step();
        check("abort_no_cmd", 64'({in_we, in_ras, in_cas}), 64'h3f);
        check("abort_no_done", 64'(done), 64'h0);

        // NOP entry with maximum skip and last: exactly 1023 NOP cycles
        put(3'd0, 1'b0, 3'd7, 15'h7fff, 10'h3ff, 1'b1, 1'b0, 1'b1);
        step();
        cmd_valid = 1'b0; cmd_last = 1'b0;
        check("nopcmd_enc", 64'({in_we, in_ras, in_cas}), 64'h3f);
        check("nopcmd_a", 64'(in_a), {34'd0, 15'h7fff, 15'h7fff});
        check("nopcmd_odt", 64'(in_odt), 64'h0);
        nops = 0;
        for (int i = 0; i < 1100; i++) begin
            step();
            nops++;
            if (done) break;
        end
        check("maxskip_nops", 64'(nops), 64'd1023);
        step();
        check("maxskip_busy", 64'(busy), 64'h0);

        // Reset in the middle of a skip-1023 gap
        put(3'd1, 1'b1, 3'd2, 15'h0321, 10'h3ff, 1'b1, 1'b1, 1'b0);
        step();
        cmd_valid = 1'b0;
        repeat (2) step();
        rst_n = 1'b0;
        step();
        check("mrst_cke", 64'(in_cke), 64'h0);
        check("mrst_odt", 64'(in_odt), 64'h0);
        check("mrst_a", 64'(in_a), 64'h0);
        check("mrst_ba", 64'(in_ba), 64'h0);
        check("mrst_busy", 64'(busy), 64'h0);
        check("mrst_ready", 64'(cmd_ready), 64'h0);
        rst_n = 1'b1;
        put(3'd2, 1'b1, 3'd1, 15'h0007, 10'd0, 1'b1, 1'b0, 1'b0);
        #1;
        check("post_rst_ready", 64'(cmd_ready), 64'h1);
        step();
        cmd_valid = 1'b0;
        check("post_rst_cas", 64'(in_cas), 64'h1);
        check("post_rst_we", 64'(in_we), 64'h3);
        check("post_rst_a", 64'(in_a), {34'd0, 15'h0007, 15'h0007});
        check("post_rst_cke", 64'(in_cke), 64'h3);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
